// File: rtl/dtlb_sv32_if.sv
// dtlb_sv32_if: LSU lookup and page-walker handshake bundle for the Sv32 data TLB.
interface dtlb_sv32_if;
  logic        flush_i;
  logic [31:0] lsu_vaddr_i;
  logic        lsu_vld_i;
  logic        lsu_is_write_i;
  logic        lsu_ready_o;
  logic        lsu_resp_vld_o;
  logic [31:0] lsu_paddr_o;
  logic [7:0]  lsu_pte_o;
  logic        lsu_excp_vld_o;
  logic [3:0]  lsu_excp_code_o;
  logic [19:0] dtlb_virt_addr_o;
  logic        dtlb_virt_addr_vld_o;
  logic        dtlb_is_write_o;
  logic        dtlb_resp_vld_i;
  logic        dtlb_is_superpage_i;
  logic [31:0] dtlb_assoc_pte_i;
  logic [3:0]  dtlb_excp_code_i;
  logic        dtlb_excp_vld_i;
  modport slave (
    input  flush_i, lsu_vaddr_i, lsu_vld_i, lsu_is_write_i,
    input  dtlb_resp_vld_i, dtlb_is_superpage_i, dtlb_assoc_pte_i, dtlb_excp_code_i, dtlb_excp_vld_i,
    output lsu_ready_o, lsu_resp_vld_o, lsu_paddr_o, lsu_pte_o, lsu_excp_vld_o, lsu_excp_code_o,
    output dtlb_virt_addr_o, dtlb_virt_addr_vld_o, dtlb_is_write_o
  );
  modport master (
    output flush_i, lsu_vaddr_i, lsu_vld_i, lsu_is_write_i,
    output dtlb_resp_vld_i, dtlb_is_superpage_i, dtlb_assoc_pte_i, dtlb_excp_code_i, dtlb_excp_vld_i,
    input  lsu_ready_o, lsu_resp_vld_o, lsu_paddr_o, lsu_pte_o, lsu_excp_vld_o, lsu_excp_code_o,
    input  dtlb_virt_addr_o, dtlb_virt_addr_vld_o, dtlb_is_write_o
  );
endinterface

// File: rtl/dtlb_sv32.sv
// dtlb_sv32: fully-associative Sv32 data TLB; hits translate in 2 cycles, misses and
// dirty-bit upgrades go to the page walker and install the returned leaf PTE.
module dtlb_sv32 #(
  parameter int ENTRIES = 8
) (
  input logic        cpu_clk_i,
  input logic        cpu_rst_i,
  dtlb_sv32_if.slave bus
);
  localparam int IW = $clog2(ENTRIES);
  typedef enum logic [1:0] {IDLE, LOOKUP, WALK} state_e;
  state_e             state_q;
  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] sp_q;
  logic [19:0]        vpn_q [ENTRIES];
  logic [19:0]        ppn_q [ENTRIES];
  logic [7:0]         flg_q [ENTRIES];
  logic [IW-1:0]      rptr_q, widx_q, match_idx, inv_idx, fill_idx;
  logic [31:0]        va_q, paddr_q, hit_pa, fill_pa;
  logic [7:0]         pte_q;
  logic [3:0]         excp_code_q;
  logic [19:0]        walk_va_q;
  logic               wr_q, kill_q, wmatch_q, resp_q, excp_vld_q, walk_vld_q, walk_wr_q;
  logic               match_any, hit, fill, all_valid;
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    inv_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && (sp_q[i] ? vpn_q[i][19:10] == va_q[31:22] : vpn_q[i] == va_q[31:12])) begin
        match_any = 1'b1;
        match_idx = IW'(i);
      end
      if (!valid_q[i]) inv_idx = IW'(i);
    end
  end
  // a store to a non-writable or clean page goes to the walker so it can set D or fault
  assign hit       = match_any && !(wr_q && !(flg_q[match_idx][2] && flg_q[match_idx][7]));
  assign hit_pa    = sp_q[match_idx] ? {ppn_q[match_idx][19:10], va_q[21:0]} : {ppn_q[match_idx], va_q[11:0]};
  assign fill_pa   = bus.dtlb_is_superpage_i ? {bus.dtlb_assoc_pte_i[29:20], va_q[21:0]}
                                             : {bus.dtlb_assoc_pte_i[29:10], va_q[11:0]};
  assign all_valid = &valid_q;
  // an upgrade walk rewrites the entry it hit so the same page never lives twice
  assign fill_idx  = wmatch_q ? widx_q : (all_valid ? rptr_q : inv_idx);
  assign fill      = state_q == WALK && bus.dtlb_resp_vld_i && !kill_q && !bus.flush_i && !bus.dtlb_excp_vld_i;
  assign bus.lsu_ready_o          = state_q == IDLE && !bus.flush_i;
  assign bus.lsu_resp_vld_o       = resp_q;
  assign bus.lsu_paddr_o          = paddr_q;
  assign bus.lsu_pte_o            = pte_q;
  assign bus.lsu_excp_vld_o       = excp_vld_q;
  assign bus.lsu_excp_code_o      = excp_code_q;
  assign bus.dtlb_virt_addr_o     = walk_va_q;
  assign bus.dtlb_virt_addr_vld_o = walk_vld_q;
  assign bus.dtlb_is_write_o      = walk_wr_q;
  always_ff @(posedge cpu_clk_i) begin
    if (fill) begin
      sp_q[fill_idx]  <= bus.dtlb_is_superpage_i;
      vpn_q[fill_idx] <= va_q[31:12];
      ppn_q[fill_idx] <= bus.dtlb_assoc_pte_i[29:10];
      flg_q[fill_idx] <= bus.dtlb_assoc_pte_i[7:0];
    end
  end
  always_ff @(posedge cpu_clk_i) begin
    if (cpu_rst_i) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      rptr_q      <= '0;
      widx_q      <= '0;
      va_q        <= '0;
      wr_q        <= 1'b0;
      kill_q      <= 1'b0;
      wmatch_q    <= 1'b0;
      resp_q      <= 1'b0;
      paddr_q     <= '0;
      pte_q       <= '0;
      excp_vld_q  <= 1'b0;
      excp_code_q <= '0;
      walk_vld_q  <= 1'b0;
      walk_va_q   <= '0;
      walk_wr_q   <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      if (bus.flush_i) valid_q <= '0;
      if (fill) begin
        valid_q[fill_idx] <= 1'b1;
        if (!wmatch_q && all_valid) rptr_q <= rptr_q + 1'b1;
      end
      case (state_q)
        IDLE: if (bus.lsu_vld_i && bus.lsu_ready_o) begin
          va_q    <= bus.lsu_vaddr_i;
          wr_q    <= bus.lsu_is_write_i;
          state_q <= LOOKUP;
        end
        LOOKUP: if (bus.flush_i) begin
          state_q <= IDLE;
        end else if (hit) begin
          resp_q      <= 1'b1;
          paddr_q     <= hit_pa;
          pte_q       <= flg_q[match_idx];
          excp_vld_q  <= 1'b0;
          excp_code_q <= '0;
          state_q     <= IDLE;
        end else begin
          walk_vld_q <= 1'b1;
          walk_va_q  <= va_q[31:12];
          walk_wr_q  <= wr_q;
          wmatch_q   <= match_any;
          widx_q     <= match_idx;
          state_q    <= WALK;
        end
        WALK: begin
          if (bus.flush_i) kill_q <= 1'b1;
          if (bus.dtlb_resp_vld_i) begin
            walk_vld_q <= 1'b0;
            kill_q     <= 1'b0;
            state_q    <= IDLE;
            if (!kill_q && !bus.flush_i) begin
              resp_q      <= 1'b1;
              excp_vld_q  <= bus.dtlb_excp_vld_i;
              excp_code_q <= bus.dtlb_excp_vld_i ? bus.dtlb_excp_code_i : 4'd0;
              if (!bus.dtlb_excp_vld_i) begin
                paddr_q <= fill_pa;
                pte_q   <= bus.dtlb_assoc_pte_i[7:0];
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
